// File: rtl/knn_feeder_if.sv
// knn_feeder_if: native request/response bus used on both sides of the
// feeder. One initiator (master) drives the request. The target (slave)
// answers with ready and read data.
//   valid/addr/wdata/wstrb : request, held stable until ready is sampled
//   rdata/ready            : response, ready is only meaningful while valid=1
interface knn_feeder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (output valid, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/knn_feeder.sv
// knn_feeder: autonomous bus initiator for the KNN accelerator.
// On start, the block fetches n_points packed training points ({Y,X}) from
// memory and writes each one to the KNN training-data register. It then
// selects each of the HW_K neighbours in turn, reads back its 8-bit label,
// and stores the label zero-extended to the destination buffer.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle pulse, only honoured in IDLE
//   src_addr, dst_addr  : word-aligned byte addresses of the point and label buffers
//   n_points            : number of training points, sampled with start
//   busy, done          : run in progress / one-cycle completion pulse
//   mem                 : master port toward system memory
//   knn                 : master port toward the KNN peripheral
module knn_feeder #(
    parameter int KNN_ADDR_W     = 8,
    parameter int DATA_W         = 32,
    parameter int MEM_ADDR_W     = 32,
    parameter int HW_K           = 4,
    parameter int CNT_W          = 16,
    parameter int KNN_DATA2_ADDR = 2,
    parameter int KNN_SEL_ADDR   = 4,
    parameter int KNN_OUT_ADDR   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] src_addr,
    input  logic [MEM_ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]      n_points,
    output logic                  busy,
    output logic                  done,
    knn_feeder_if.master          mem,
    knn_feeder_if.master          knn
);
    localparam int J_W = $clog2(HW_K + 1);
    localparam logic [J_W-1:0]        J_END   = J_W'(HW_K);
    localparam logic [KNN_ADDR_W-1:0] A_DATA2 = KNN_ADDR_W'(KNN_DATA2_ADDR);
    localparam logic [KNN_ADDR_W-1:0] A_SEL   = KNN_ADDR_W'(KNN_SEL_ADDR);
    localparam logic [KNN_ADDR_W-1:0] A_OUT   = KNN_ADDR_W'(KNN_OUT_ADDR);

    typedef enum logic [3:0] {
        IDLE, MEM_RD, PT_WR, GAP, SEL_WR, GAP2, OUT_RD, DST_WR, DONE
    } state_t;

    state_t                state, state_n;
    logic [MEM_ADDR_W-1:0] src_q, dst_q;
    logic [CNT_W-1:0]      n_q, i;
    logic [J_W-1:0]        j;
    logic [DATA_W-1:0]     pt;
    logic                  mem_ack;   // cycle after a memory handshake, valid already low
    logic                  mem_hs, knn_hs;

    assign mem_hs = mem.valid && mem.ready;
    assign knn_hs = knn.valid && knn.ready;

    // Only the label byte of the KNN read data matters.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^knn.rdata[DATA_W-1:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Memory states linger one cycle after ready (mem_ack) so that a KNN request
    // never follows a memory request back-to-back. The GAP states keep knn.valid
    // low for one cycle after each KNN transaction because KNN ready lags valid.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (start) state_n = (n_points == '0) ? SEL_WR : MEM_RD;
            MEM_RD: if (mem_ack) state_n = PT_WR;
            PT_WR:  if (knn_hs) state_n = GAP;
            GAP:    state_n = (i == n_q) ? SEL_WR : MEM_RD;
            SEL_WR: if (knn_hs) state_n = GAP2;
            GAP2:   state_n = OUT_RD;
            OUT_RD: if (knn_hs) state_n = DST_WR;
            DST_WR: if (mem_ack) state_n = (j == J_END) ? DONE : SEL_WR;
            DONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Each request is launched on the edge that enters its state, so valid and
    // the request fields are registered outputs from the first cycle onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            n_q       <= '0;
            i         <= '0;
            j         <= '0;
            pt        <= '0;
            mem_ack   <= 1'b0;
            mem.valid <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            mem.wstrb <= '0;
            knn.valid <= 1'b0;
            knn.addr  <= '0;
            knn.wdata <= '0;
            knn.wstrb <= '0;
        end else begin
            done    <= (state != DONE) && (state_n == DONE);
            mem_ack <= 1'b0;

            if (state == IDLE && start) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                n_q   <= n_points;
                i     <= '0;
                j     <= '0;
                busy  <= 1'b1;
            end else if (state != DONE && state_n == DONE) begin
                busy <= 1'b0;
            end

            if (mem_hs) begin
                mem.valid <= 1'b0;
                mem_ack   <= 1'b1;
                if (state == MEM_RD) pt <= mem.rdata;
                else                 j  <= j + 1'b1;
            end

            if (knn_hs) begin
                knn.valid <= 1'b0;
                if (state == PT_WR) i <= i + 1'b1;
            end

            if (state_n != state) begin
                case (state_n)
                    MEM_RD: begin
                        // src_q/i are still being loaded on the start edge.
                        mem.valid <= 1'b1;
                        mem.addr  <= (state == IDLE) ? src_addr
                                                     : src_q + (MEM_ADDR_W'(i) << 2);
                        mem.wdata <= '0;
                        mem.wstrb <= '0;
                    end
                    PT_WR: begin
                        knn.valid <= 1'b1;
                        knn.addr  <= A_DATA2;
                        knn.wdata <= pt;
                        knn.wstrb <= '1;
                    end
                    SEL_WR: begin
                        knn.valid <= 1'b1;
                        knn.addr  <= A_SEL;
                        knn.wdata <= (state == IDLE) ? '0 : DATA_W'(j);
                        knn.wstrb <= '1;
                    end
                    OUT_RD: begin
                        knn.valid <= 1'b1;
                        knn.addr  <= A_OUT;
                        knn.wdata <= '0;
                        knn.wstrb <= '0;
                    end
                    DST_WR: begin
                        // Entered on the OUT_RD handshake edge, so the label is
                        // taken straight from the response.
                        mem.valid <= 1'b1;
                        mem.addr  <= dst_q + (MEM_ADDR_W'(j) << 2);
                        mem.wdata <= {{(DATA_W-8){1'b0}}, knn.rdata[7:0]};
                        mem.wstrb <= '1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_knn_feeder.sv
// tb_knn_feeder: directed bench for knn_feeder. A table of runs (point count,
// buffers, memory latency, expected cycle count) is applied in a loop. Memory
// and KNN behavioural models log every transaction, and the logs are checked
// against addresses, data and labels computed here. Hand-written sequences
// cover reset state and a reset in the middle of a run.
module tb_knn_feeder;
    localparam int HW_K = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] n_points;
    logic        busy, done;

    knn_feeder_if #(.ADDR_W(32), .DATA_W(32)) mif ();
    knn_feeder_if #(.ADDR_W(8),  .DATA_W(32)) kif ();

    knn_feeder #(.KNN_ADDR_W(8), .DATA_W(32), .MEM_ADDR_W(32), .HW_K(HW_K), .CNT_W(16),
                 .KNN_DATA2_ADDR(2), .KNN_SEL_ADDR(4), .KNN_OUT_ADDR(5)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .n_points(n_points), .busy(busy), .done(done), .mem(mif), .knn(kif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    typedef struct {
        int          n;
        logic [31:0] src;
        logic [31:0] dst;
        int          dly;
        bit          restart;
        int          exp_cyc;
    } vec_t;

    txn_t        mem_log[$];
    txn_t        knn_log[$];
    logic [7:0]  lab_tab [0:HW_K-1];
    logic [1:0]  ksel;
    int          mem_dly = 1;
    int          mem_cnt = 0;
    int          both_cnt = 0;
    int          stab_err = 0;
    logic        m_pend, k_pend;
    logic [67:0] m_snap, k_snap;
    int          checks = 0;
    int          errors = 0;

    function automatic txn_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.addr = a; t.wdata = d; t.wstrb = s;
        return t;
    endfunction

    // Training word stored at a byte address: Y in [31:16], X in [15:0].
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'h3C3C, a[15:0] + 16'h0101};
    endfunction

    // Memory model: ready after mem_dly cycles of valid, for one cycle.
    always @(posedge clk) begin
        if (rst) begin
            mif.ready <= 1'b0;
            mif.rdata <= '0;
            mem_cnt   <= 0;
        end else if (mif.valid && mif.ready) begin
            mif.ready <= 1'b0;
            mem_log.push_back(mk(mif.addr, mif.wdata, mif.wstrb));
        end else if (mif.valid) begin
            if (mem_cnt >= mem_dly - 1) begin
                mif.ready <= 1'b1;
                mif.rdata <= pat(mif.addr);
                mem_cnt   <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    // KNN model: ready one cycle after valid. The label read carries garbage
    // in the upper bytes so that zero-extension is observable.
    always @(posedge clk) begin
        if (rst) begin
            kif.ready <= 1'b0;
            kif.rdata <= '0;
            ksel      <= '0;
        end else if (kif.valid && kif.ready) begin
            kif.ready <= 1'b0;
            knn_log.push_back(mk(32'(kif.addr), kif.wdata, kif.wstrb));
            if (kif.addr == 8'd4 && kif.wstrb != 4'h0) ksel <= kif.wdata[1:0];
        end else if (kif.valid) begin
            kif.ready <= 1'b1;
            kif.rdata <= (kif.addr == 8'd5) ? {24'hABCDEF, lab_tab[ksel]} : 32'h0;
        end
    end

    // Protocol monitors: ports never both valid, and requests stable while pending.
    always @(posedge clk) begin
        if (mif.valid && kif.valid) both_cnt <= both_cnt + 1;
        if (rst) begin
            m_pend <= 1'b0;
            k_pend <= 1'b0;
        end else begin
            if (m_pend && (!mif.valid || {mif.addr, mif.wdata, mif.wstrb} != m_snap))
                stab_err <= stab_err + 1;
            if (k_pend && (!kif.valid || {24'h0, kif.addr, kif.wdata, kif.wstrb} != k_snap))
                stab_err <= stab_err + 1;
            m_pend <= mif.valid && !mif.ready;
            k_pend <= kif.valid && !kif.ready;
            m_snap <= {mif.addr, mif.wdata, mif.wstrb};
            k_snap <= {24'h0, kif.addr, kif.wdata, kif.wstrb};
        end
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int v, input vec_t t);
        int cyc;
        int b0, s0;
        mem_log.delete();
        knn_log.delete();
        mem_dly = t.dly;
        b0 = both_cnt;
        s0 = stab_err;
        @(negedge clk);
        src_addr = t.src;
        dst_addr = t.dst;
        n_points = 16'(t.n);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 2;   // start cycle plus the one now in progress
        chk($sformatf("v%0d busy_rise", v), busy, 1'b1);
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (t.restart && cyc == 10) begin
                start    = 1'b1;
                n_points = 16'd7;
                src_addr = 32'h0;
            end else begin
                start = 1'b0;
            end
        end
        chk($sformatf("v%0d cycles", v), cyc, t.exp_cyc);
        chk($sformatf("v%0d busy_at_done", v), busy, 1'b0);
        @(posedge clk); #1;
        chk($sformatf("v%0d done_width", v), done, 1'b0);
        chk($sformatf("v%0d mem_count", v), mem_log.size(), t.n + HW_K);
        chk($sformatf("v%0d knn_count", v), knn_log.size(), t.n + 2 * HW_K);
        for (int k = 0; k < t.n; k++) begin
            if (k < mem_log.size())
                chk($sformatf("v%0d mem_rd%0d", v, k), {mem_log[k].addr, mem_log[k].wstrb},
                    {t.src + 32'(4 * k), 4'h0});
            if (k < knn_log.size())
                chk($sformatf("v%0d pt_wr%0d", v, k),
                    {knn_log[k].addr, knn_log[k].wdata, knn_log[k].wstrb},
                    {32'd2, pat(t.src + 32'(4 * k)), 4'hF});
        end
        for (int jj = 0; jj < HW_K; jj++) begin
            if (t.n + jj < mem_log.size())
                chk($sformatf("v%0d dst_wr%0d", v, jj),
                    {mem_log[t.n + jj].addr, mem_log[t.n + jj].wdata, mem_log[t.n + jj].wstrb},
                    {t.dst + 32'(4 * jj), 24'h0, lab_tab[jj], 4'hF});
            if (t.n + 2 * jj + 1 < knn_log.size()) begin
                chk($sformatf("v%0d sel_wr%0d", v, jj),
                    {knn_log[t.n + 2 * jj].addr, knn_log[t.n + 2 * jj].wdata, knn_log[t.n + 2 * jj].wstrb},
                    {32'd4, 32'(jj), 4'hF});
                chk($sformatf("v%0d out_rd%0d", v, jj),
                    {knn_log[t.n + 2 * jj + 1].addr, knn_log[t.n + 2 * jj + 1].wstrb},
                    {32'd5, 4'h0});
            end
        end
        chk($sformatf("v%0d both_valid", v), both_cnt - b0, 0);
        chk($sformatf("v%0d req_stable", v), stab_err - s0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        bit   found;
        // n, src, dst, mem latency, start-while-busy, expected cycles start..done
        vecs[0] = '{3, 32'h0000_0100, 32'h0000_0200, 1, 1'b0, 52};
        vecs[1] = '{0, 32'h0000_0100, 32'h0000_0200, 1, 1'b0, 34};
        vecs[2] = '{2, 32'h0000_0140, 32'h0000_0300, 5, 1'b0, 70};
        vecs[3] = '{3, 32'hFFFF_FFF8, 32'hFFFF_FFF4, 1, 1'b0, 52};
        vecs[4] = '{2, 32'h0000_0180, 32'h0000_0200, 1, 1'b1, 46};
        lab_tab[0] = 8'hA5;
        lab_tab[1] = 8'h3C;
        lab_tab[2] = 8'h5A;
        lab_tab[3] = 8'hC3;

        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        n_points = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst mem_valid", mif.valid, 1'b0);
        chk("rst knn_valid", kif.valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle busy", busy, 1'b0);
        chk("idle valids", {mif.valid, kif.valid}, 2'b00);

        for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

        // Reset while the second point's KNN write is pending.
        mem_log.delete();
        knn_log.delete();
        mem_dly = 1;
        @(negedge clk);
        src_addr = 32'h100;
        dst_addr = 32'h200;
        n_points = 16'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (knn_log.size() == 1 && kif.valid) found = 1'b1;
        end
        chk("reach pt_wr2", found, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst knn_valid", kif.valid, 1'b0);
        chk("midrst mem_valid", mif.valid, 1'b0);
        chk("midrst busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_vec(5, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/knn_feeder.md
# knn_feeder

Native-bus initiator that drives the KNN accelerator autonomously. On `start` it fetches `n_points` packed training points from system memory, writes each into the accelerator's training-data register, then reads back all `HW_K` neighbour labels and stores them to a destination buffer in memory. It sits between the system memory interconnect (master port) and the KNN peripheral's slave port, and relieves the CPU of the per-point write loop.

## Interface
- `ADDR_W`, `KNN_ADDR_W`: KNN slave address width.
- `DATA_W`, `DATA_W` (32): bus word width; training point packs Y in [31:16] and X in [15:0].
- `MEM_ADDR_W`, 32: memory-port byte address width.
- `HW_K`, `HW_K`: number of labels read back.
- `CNT_W`, 16: point-counter width.
- `KNN_DATA2_ADDR`, 2: KNN word address of the training-point register.
- `KNN_SEL_ADDR`, 4: KNN word address of the neighbour-select register.
- `KNN_OUT_ADDR`, 5: KNN word address of the 8-bit label output (`rdata[7:0]`).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; sampled only in IDLE.
- `src_addr` in MEM_ADDR_W: byte address of the first training point (word aligned).
- `dst_addr` in MEM_ADDR_W: byte address of the label buffer (word aligned).
- `n_points` in CNT_W: number of training points; sampled with `start`.
- `busy` out 1: high from the cycle after accepted `start` until DONE.
- `done` out 1: one-cycle pulse when the final label write completes.
- `mem_valid`/`mem_addr`/`mem_wdata`/`mem_wstrb` out 1/MEM_ADDR_W/DATA_W/DATA_W/8: memory request.
- `mem_rdata`/`mem_ready` in DATA_W/1: memory response.
- `knn_valid`/`knn_addr`/`knn_wdata`/`knn_wstrb` out 1/ADDR_W/DATA_W/DATA_W/8: KNN request.
- `knn_rdata`/`knn_ready` in DATA_W/1: KNN response.

## Operation
- All outputs are registered. Reset value is 0 for every output, the FSM is in IDLE, and the counters are 0.
- Native handshake: the initiator holds `valid`, addr, wdata and wstrb stable until it samples `ready`=1. It deasserts `valid` in the next cycle. `ready` is ignored while `valid`=0. After each KNN transaction, `knn_valid` stays low for at least 1 cycle, because KNN `ready` lags `valid` by one cycle.
- Write: `wstrb`=4'hF. Read: `wstrb`=0.
- FSM states:
  - IDLE: on `start`, latch `src_addr`, `dst_addr` and `n_points`, and clear `i` and `j`. If `n_points`=0, go to SEL_WR. Otherwise go to MEM_RD.
  - MEM_RD: read `src+4*i`. On `mem_ready`, latch `mem_rdata` into `pt` and go to PT_WR.
  - PT_WR: KNN write `pt` to `KNN_DATA2_ADDR`. On `knn_ready`, go to GAP and increment `i`.
  - GAP: one idle cycle. If `i`==`n_points`, go to SEL_WR. Otherwise go to MEM_RD.
  - SEL_WR: KNN write `j` to `KNN_SEL_ADDR`. On ready, go to GAP2.
  - GAP2: one idle cycle, then go to OUT_RD.
  - OUT_RD: KNN read `KNN_OUT_ADDR`. On ready, latch `knn_rdata[7:0]` and go to DST_WR.
  - DST_WR: memory write `{24'b0,label}` to `dst+4*j`. On `mem_ready`, increment `j`. If `j`==`HW_K`-1 before the increment, go to DONE. Otherwise go to SEL_WR.
  - DONE: pulse `done`, drop `busy`, go to IDLE.
- Address arithmetic is modulo 2^MEM_ADDR_W. Wrap past all-ones is silent.
- `start` while `busy` is ignored.
- Asserting `rst` mid-transaction immediately drops all `valid` signals and returns to IDLE. No partial state is retained.

## Timing
- `busy` rises 1 cycle after `start`.
- With zero-wait memory (ready 1 cycle after valid) and KNN ready 1 cycle after valid:
  - Each point costs 6 cycles: MEM_RD 2, PT_WR 2, GAP 1, plus 1 cycle for the `valid` drop.
  - Each label costs 8 cycles.
- Total = 1 + 6·N + 8·HW_K + 1 cycles from `start` to `done`.
- `done` and the `busy` fall occur in the same cycle.
- The memory and KNN ports are never both valid in the same cycle.

## Test plan
- Reset with `busy`=0, `done`=0 and all `valid` low, then `start` with N=3 from `src`=0x100 -> memory reads at 0x100, 0x104 and 0x108. KNN writes to `KNN_DATA2_ADDR` carry the exact words read, in order.
- N=0, HW_K=4, `dst`=0x200 -> no memory reads. SEL writes occur with values 0..3. Labels are written zero-extended to 0x200..0x20C. `done` arrives at 1+32+1 cycles.
- Memory ready delayed 5 cycles -> the request is held stable for 5 cycles and no extra transactions occur. Total cycle count grows by exactly 4 per delayed access.
- `start` pulsed again while `busy` -> ignored. Transaction counts are unchanged.
- `rst` asserted during PT_WR of point 2 -> `knn_valid` is 0 in the same cycle. A subsequent `start` restarts from `src_addr` with `i`=0.
- KNN model returning labels 0xA5, 0x3C, ... -> `dst` words hold 0x000000A5, 0x0000003C, .... `done` pulses for exactly 1 cycle.
